// File: rtl/sdft_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sdft_pkg
// Brief   : Shared types and defaults for the sliding-DFT bin scheduler.
// Rev     : 1.0  initial release
// ============================================================================
package sdft_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    FETCH = 3'd2,
    ISSUE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int SDFT_DATA_WIDTH = 8;
  localparam int SDFT_WINDOW     = 32;
  localparam int SDFT_FREQ_BINS  = 16;

  // Difference of two unsigned DW-bit samples needs one extra sign bit
  function automatic int delta_width(input int dw);
    return dw + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdft_bin_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sdft_bin_scheduler_if
// Brief   : Sample-in / bin-op-out handshake bundle. master = scheduler side,
//           slave = ADC sample source plus complex MAC.
// Rev     : 1.0  initial release
// ============================================================================
interface sdft_bin_scheduler_if
  import sdft_pkg::*;
#(
  parameter int DATA_WIDTH = SDFT_DATA_WIDTH,
  parameter int FREQ_BINS  = SDFT_FREQ_BINS
);
  localparam int BIN_W   = $clog2(FREQ_BINS);
  localparam int DELTA_W = delta_width(DATA_WIDTH);

  logic                  sample_valid;
  logic [DATA_WIDTH-1:0] sample;
  logic                  sample_ready;
  logic                  op_valid;
  logic                  op_ready;
  logic [BIN_W-1:0]      op_bin;
  logic [DELTA_W-1:0]    op_delta;
  logic                  op_last;

  modport master (
    input  sample_valid, sample, op_ready,
    output sample_ready, op_valid, op_bin, op_delta, op_last
  );

  modport slave (
    output sample_valid, sample, op_ready,
    input  sample_ready, op_valid, op_bin, op_delta, op_last
  );

endinterface
`default_nettype wire

// File: rtl/sdft_delay_line.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sdft_delay_line
// Brief   : WINDOW x DATA_WIDTH single-port RAM addressed by an internal
//           wrapping pointer. Read is registered and read-first, so the old
//           entry at ptr is available the cycle after it is addressed.
// Rev     : 1.0  initial release
// ============================================================================
module sdft_delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int WINDOW     = 32
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  input  wire logic                      we,
  input  wire logic [DATA_WIDTH-1:0]     wdata,
  input  wire logic                      adv,
  output logic [$clog2(WINDOW)-1:0]      ptr,
  output logic [DATA_WIDTH-1:0]          rdata
);
  localparam int PTR_W = $clog2(WINDOW);

  logic [DATA_WIDTH-1:0] mem_q [WINDOW];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [PTR_W-1:0]      ptr_q;
  logic [PTR_W-1:0]      ptr_d;

  // Pointer advance with explicit wrap at the end of the window
  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      if (ptr_q == PTR_W'(WINDOW - 1)) ptr_d = '0;
      else                             ptr_d = ptr_q + 1'b1;
    end
  end

  // Pointer register; storage itself is not reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Single-port RAM, read-first: rdata_q returns the value before any write
  always_ff @(posedge clk) begin
    if (we) mem_q[ptr_q] <= wdata;
    rdata_q <= mem_q[ptr_q];
  end

  assign ptr   = ptr_q;
  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sdft_bin_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sdft_bin_scheduler
// Brief   : Sliding-DFT update sequencer. Keeps the window delay line, forms
//           delta = x[n] - x[n-WINDOW] and issues one MAC op per bin, then
//           pulses frame_done. Samples arriving outside IDLE are dropped and
//           flagged as overrun.
// Config  : SDFT_SCHED_OVERRUN_CNT_EN adds an 8-bit saturating overrun_count
//           output; overrun then reads as overrun_count != 0.
// Rev     : 1.0  initial release
// ============================================================================
module sdft_bin_scheduler
  import sdft_pkg::*;
#(
  parameter int DATA_WIDTH = SDFT_DATA_WIDTH,
  parameter int WINDOW     = SDFT_WINDOW,
  parameter int FREQ_BINS  = SDFT_FREQ_BINS
) (
  input  wire logic            clk,
  input  wire logic            reset,
  sdft_bin_scheduler_if.master bus,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 overrun
`ifdef SDFT_SCHED_OVERRUN_CNT_EN
  ,
  output logic [7:0]           overrun_count
`endif
);
  localparam int BIN_W   = $clog2(FREQ_BINS);
  localparam int PTR_W   = $clog2(WINDOW);
  localparam int DELTA_W = delta_width(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [BIN_W-1:0]      k_q, k_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic [DELTA_W-1:0]    delta_q, delta_d;

  logic                  dl_we;
  logic                  dl_adv;
  logic [DATA_WIDTH-1:0] dl_wdata;
  logic [PTR_W-1:0]      dl_ptr;
  logic [DATA_WIDTH-1:0] dl_rdata;

  // A sample strobe outside IDLE is always lost, including during CLEAR
  logic                  drop;
  assign drop = bus.sample_valid && (state_q != IDLE);

  sdft_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .WINDOW     (WINDOW)
  ) u_delay_line (
    .clk   (clk),
    .reset (reset),
    .we    (dl_we),
    .wdata (dl_wdata),
    .adv   (dl_adv),
    .ptr   (dl_ptr),
    .rdata (dl_rdata)
  );

  // Next-state, bin counter, delta and delay-line control
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    sample_d = sample_q;
    delta_d  = delta_q;
    dl_we    = 1'b0;
    dl_adv   = 1'b0;
    dl_wdata = sample_q;
    case (state_q)
      CLEAR: begin
        // Pointer sweeps 0..WINDOW-1 and wraps back to 0 on the last write
        dl_we    = 1'b1;
        dl_adv   = 1'b1;
        dl_wdata = '0;
        if (dl_ptr == PTR_W'(WINDOW - 1)) state_d = IDLE;
      end
      IDLE: begin
        // Delay line is already addressed at ptr, its read lands in FETCH
        if (bus.sample_valid) begin
          sample_d = bus.sample;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        delta_d = {1'b0, sample_q} - {1'b0, dl_rdata};
        dl_we   = 1'b1;
        dl_adv  = 1'b1;
        k_d     = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (bus.op_ready) begin
          if (k_q == BIN_W'(FREQ_BINS - 1)) state_d = DONE;
          else                              k_d     = k_q + 1'b1;
        end
      end
      DONE: begin
        k_d     = '0;
        state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Main state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CLEAR;
      k_q      <= '0;
      sample_q <= '0;
      delta_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      sample_q <= sample_d;
      delta_q  <= delta_d;
    end
  end

`ifdef SDFT_SCHED_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  // Saturating count of dropped samples
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (drop && (ovr_cnt_q != 8'hFF)) ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  // Overrun counter register
  always_ff @(posedge clk) begin
    if (reset) ovr_cnt_q <= '0;
    else       ovr_cnt_q <= ovr_cnt_d;
  end

  assign overrun_count = ovr_cnt_q;
  assign overrun       = (ovr_cnt_q != 8'd0);
`else
  logic overrun_q, overrun_d;

  // Sticky overrun flag, cleared only by reset
  always_comb begin
    overrun_d = overrun_q | drop;
  end

  // Overrun flag register
  always_ff @(posedge clk) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`endif

  assign bus.sample_ready = (state_q == IDLE);
  assign bus.op_valid     = (state_q == ISSUE);
  assign bus.op_bin       = k_q;
  assign bus.op_delta     = delta_q;
  assign bus.op_last      = (state_q == ISSUE) && (k_q == BIN_W'(FREQ_BINS - 1));
  assign frame_done       = (state_q == DONE);
  assign busy             = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdft_bin_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_sdft_bin_scheduler
// Brief   : Directed self-checking bench. A reference delay line predicts
//           each sample's delta, which is queued on drive and popped at the
//           first op of the frame. Build with SDFT_SCHED_OVERRUN_CNT_EN to
//           also check overrun_count.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sdft_bin_scheduler;
  localparam int DW  = 8;
  localparam int WIN = 32;
  localparam int FB  = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sdft_bin_scheduler_if #(.DATA_WIDTH(DW), .FREQ_BINS(FB)) bus ();

  logic frame_done;
  logic busy;
  logic overrun;
`ifdef SDFT_SCHED_OVERRUN_CNT_EN
  logic [7:0] overrun_count;
`endif

  sdft_bin_scheduler #(
    .DATA_WIDTH (DW),
    .WINDOW     (WIN),
    .FREQ_BINS  (FB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .frame_done (frame_done),
    .busy       (busy),
    .overrun    (overrun)
`ifdef SDFT_SCHED_OVERRUN_CNT_EN
    ,
    .overrun_count (overrun_count)
`endif
  );

  int            pass_cnt  = 0;
  int            total_cnt = 0;
  logic [DW-1:0] mdl [WIN];
  int            mptr;
  logic [DW:0]   exp_q [$];
  logic [DW:0]   last_delta;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic model_reset();
    for (int i = 0; i < WIN; i++) mdl[i] = '0;
    mptr = 0;
    exp_q.delete();
  endtask

  // Hold reset, check reset values, then time the CLEAR sweep
  task automatic do_reset();
    int n;
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    bus.op_ready     = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy",       32'(busy), 1);
    chk("rst_ready",      32'(bus.sample_ready), 0);
    chk("rst_op_valid",   32'(bus.op_valid), 0);
    chk("rst_op_bin",     32'(bus.op_bin), 0);
    chk("rst_op_delta",   32'(bus.op_delta), 0);
    chk("rst_op_last",    32'(bus.op_last), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overrun",    32'(overrun), 0);
`ifdef SDFT_SCHED_OVERRUN_CNT_EN
    chk("rst_ovr_count",  32'(overrun_count), 0);
`endif
    model_reset();
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("clear_cycles",  32'(n), 32);
    chk("idle_ready",    32'(bus.sample_ready), 1);
    chk("idle_op_valid", 32'(bus.op_valid), 0);
    chk("idle_op_bin",   32'(bus.op_bin), 0);
    chk("idle_op_delta", 32'(bus.op_delta), 0);
    chk("idle_op_last",  32'(bus.op_last), 0);
  endtask

  // Wait for IDLE, queue the predicted delta and drive one sample
  task automatic drive_sample(input logic [DW-1:0] s);
    int n;
    n = 0;
    while (bus.sample_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_sample", 32'(bus.sample_ready), 1);
    exp_q.push_back({1'b0, s} - {1'b0, mdl[mptr]});
    mdl[mptr] = s;
    mptr      = (mptr + 1) % WIN;
    bus.sample       = s;
    bus.sample_valid = 1'b1;
  endtask

  // pattern 0: op_ready always high; pattern 1: repeating 1,0,0,1.
  // inject_at > 0 strobes a rogue sample that many cycles after accept.
  task automatic run_sample(input logic [DW-1:0] s, input int pattern, input int inject_at);
    int          c;
    int          k;
    bit          got;
    bit          done;
    logic        rdy;
    logic [DW:0] exp_d;
    drive_sample(s);
    c     = 0;
    k     = 0;
    got   = 1'b0;
    done  = 1'b0;
    exp_d = '0;
    while (!done && c < 300) begin
      @(negedge clk);
      c++;
      bus.sample_valid = (c == inject_at);
      if (c == inject_at) bus.sample = 8'd99;
      rdy          = (pattern == 0) ? 1'b1 : (((c % 4) == 1) || ((c % 4) == 0));
      bus.op_ready = rdy;
      if (bus.op_valid === 1'b1) begin
        if (!got) begin
          exp_d      = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          got        = 1'b1;
          last_delta = bus.op_delta;
        end
        chk("op_bin",   32'(bus.op_bin), k);
        chk("op_delta", 32'(bus.op_delta), 32'(exp_d));
        chk("op_last",  32'(bus.op_last), 32'(k == FB - 1));
        if (rdy) begin
          if (pattern == 0) chk("op_cycle", c, k + 2);
          k++;
        end
      end
      if (frame_done === 1'b1) begin
        done = 1'b1;
        if (pattern == 0) chk("done_latency", c, 18);
        chk("ops_accepted", k, FB);
      end
    end
    chk("frame_done_seen", 32'(done), 1);
    bus.sample_valid = 1'b0;
    bus.op_ready     = 1'b1;
  endtask

  initial begin
    int n;
    bus.sample_valid = 1'b0;
    bus.sample       = '0;
    bus.op_ready     = 1'b1;
    last_delta       = '0;

    // Reset defaults and CLEAR duration
    do_reset();

    // Single sample after clear, op_ready tied high
    run_sample(8'd200, 0, -1);
    chk("delta_200", 32'(last_delta), 200);

    // Fill the full window, then wrap the write pointer
    do_reset();
    for (int i = 0; i <= 32; i++) run_sample(8'(i), 0, -1);
    chk("delta_wrap_32", 32'(last_delta), 32);
    run_sample(8'd10, 0, -1);
    chk("delta_wrap_9", 32'(last_delta), 9);

    // Stalled handshake: hold during op_ready low
    run_sample(8'd50, 1, -1);
    chk("delta_stall", 32'(last_delta), 48);

    // Rogue sample mid-frame is dropped
    chk("overrun_before", 32'(overrun), 0);
    run_sample(8'd7, 0, 3);
    chk("delta_inflight", 32'(last_delta), 4);
    chk("overrun_set", 32'(overrun), 1);
`ifdef SDFT_SCHED_OVERRUN_CNT_EN
    chk("overrun_count_1", 32'(overrun_count), 1);
`endif
    run_sample(8'd20, 0, -1);
    chk("dropped_not_stored", 32'(last_delta), 16);
    chk("overrun_sticky", 32'(overrun), 1);

    // Reset while op_bin == 7
    drive_sample(8'd123);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    n = 0;
    while (!(bus.op_valid === 1'b1 && bus.op_bin == 4'd7) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_bin7", 32'(bus.op_bin), 7);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_op_valid", 32'(bus.op_valid), 0);
    chk("midrst_no_done",  32'(frame_done), 0);
    do_reset();
    run_sample(8'd5, 0, -1);
    chk("delta_after_rst", 32'(last_delta), 5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard time limit so a hung DUT still ends the run
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
